// File: rtl/obstacle.sv
// Dino-Run scrolling obstacle. Spawns one cactus or bird at the right edge and
// moves it left once per frame. Reports per scanned pixel whether it is obstacle-coloured.

package dinorun_pkg;
    localparam int ScreenWidth  = 640;
    localparam int ScreenHeight = 480;
endpackage

module obstacle
    import dinorun_pkg::*;
#(
    parameter bit IsBird  = 1'b0,
    parameter int Speed   = 4,
    parameter int GroundY = 400
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       next_frame_i,
    input  logic       spawn_i,
    input  logic [7:0] rand_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       pixel_o,
    output logic       active_o
);

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    localparam logic signed [10:0] SpawnX  = 11'(ScreenWidth);
    localparam logic signed [10:0] SpeedX  = 11'(Speed);
    localparam logic        [9:0]  GroundL = 10'(GroundY);

    state_e             state_q, state_d;
    logic signed [10:0] x_q, x_d;
    logic        [9:0]  yTop_q, yTop_d;
    logic        [5:0]  w_q, w_d;
    logic        [5:0]  h_q, h_d;
    logic               flap_q, flap_d;
    logic        [2:0]  frameCnt_q, frameCnt_d;

    logic        [5:0]  spawnW;
    logic        [5:0]  spawnH;
    logic        [9:0]  spawnY;
    logic signed [10:0] movedX;
    logic signed [10:0] wExt;

    logic signed [11:0] pxS, xS, xEnd, localX;
    logic        [10:0] yEnd;
    logic        [9:0]  localY;
    logic               inX, inY, spriteBit;

    // Only the two low random bits pick the variant; the rest is deliberately ignored.
    logic unusedRand;
    assign unusedRand = ^rand_i[7:2];

    // Variant geometry that would be latched if a spawn happened this cycle.
    always_comb begin
        spawnW = 6'd12;
        spawnH = 6'd24;
        spawnY = GroundL - 10'd24;
        if (IsBird) begin
            spawnW = 6'd32;
            spawnH = 6'd16;
            case (rand_i[1:0])
                2'd0:    spawnY = GroundL - 10'd16;
                2'd2:    spawnY = GroundL - 10'd64;
                default: spawnY = GroundL - 10'd40;
            endcase
        end else begin
            spawnW = rand_i[0] ? 6'd24 : 6'd12;
            spawnH = rand_i[1] ? 6'd48 : 6'd24;
            spawnY = GroundL - {4'b0000, spawnH};
        end
    end

    assign movedX = x_q - SpeedX;
    assign wExt   = {5'b00000, w_q};

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        yTop_d     = yTop_q;
        w_d        = w_q;
        h_d        = h_q;
        flap_d     = flap_q;
        frameCnt_d = frameCnt_q;
        case (state_q)
            StIdle: begin
                if (next_frame_i && spawn_i) begin
                    state_d    = StActive;
                    x_d        = SpawnX;
                    yTop_d     = spawnY;
                    w_d        = spawnW;
                    h_d        = spawnH;
                    flap_d     = 1'b0;
                    frameCnt_d = 3'd0;
                end
            end
            StActive: begin
                if (next_frame_i) begin
                    x_d = movedX;
                    if (IsBird) begin
                        frameCnt_d = frameCnt_q + 3'd1;
                        if (frameCnt_q == 3'd7) begin
                            flap_d = ~flap_q;
                        end
                    end
                    // Fully past the left edge: despawn; a respawn needs the next pulse.
                    if (movedX <= -wExt) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            x_q        <= SpawnX;
            yTop_q     <= 10'd0;
            w_q        <= 6'd0;
            h_q        <= 6'd0;
            flap_q     <= 1'b0;
            frameCnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            yTop_q     <= yTop_d;
            w_q        <= w_d;
            h_q        <= h_d;
            flap_q     <= flap_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Horizontal test is signed so obstacles hanging off the left edge clip correctly.
    assign pxS    = {2'b00, pixel_x_i};
    assign xS     = {x_q[10], x_q};
    assign xEnd   = xS + {6'b000000, w_q};
    assign inX    = (pxS >= xS) && (pxS < xEnd);
    assign yEnd   = {1'b0, yTop_q} + {5'b00000, h_q};
    assign inY    = ({1'b0, pixel_y_i} >= {1'b0, yTop_q}) && ({1'b0, pixel_y_i} < yEnd);
    assign localX = pxS - xS;
    assign localY = pixel_y_i - yTop_q;

    always_comb begin
        spriteBit = 1'b1;
        if (IsBird) begin
            spriteBit = 1'b0;
            if (localY >= 10'd6 && localY <= 10'd9) begin
                spriteBit = 1'b1;
            end else if (localX >= 12'sd12 && localX <= 12'sd19) begin
                spriteBit = flap_q ? (localY >= 10'd10) : (localY <= 10'd5);
            end
        end
    end

    assign active_o = (state_q == StActive);
    assign pixel_o  = active_o && inX && inY && spriteBit;

endmodule

// File: tb/tb_obstacle.sv
// Scoreboard bench for obstacle: drives a cactus and a bird instance with shared inputs
// and compares both against an integer-level model of the game rules.

module tb_obstacle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nf = 1'b0;
    logic       sp = 1'b0;
    logic [7:0] rnd = 8'h00;
    logic [9:0] pixX = 10'd0;
    logic [9:0] pixY = 10'd0;
    logic       pixC, actC, pixB, actB;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    obstacle #(.IsBird(1'b0), .Speed(4), .GroundY(400)) dutCactus (
        .clk_i(clk), .rst_i(rst), .next_frame_i(nf), .spawn_i(sp), .rand_i(rnd),
        .pixel_x_i(pixX), .pixel_y_i(pixY), .pixel_o(pixC), .active_o(actC)
    );

    obstacle #(.IsBird(1'b1), .Speed(4), .GroundY(400)) dutBird (
        .clk_i(clk), .rst_i(rst), .next_frame_i(nf), .spawn_i(sp), .rand_i(rnd),
        .pixel_x_i(pixX), .pixel_y_i(pixY), .pixel_o(pixB), .active_o(actB)
    );

    typedef struct {
        string tag;
        bit    pixC;
        bit    actC;
        bit    pixB;
        bit    actB;
    } exp_t;

    exp_t sb[$];

    // Reference model: index 0 = cactus, 1 = bird; mFrames counts pulses since spawn.
    int mAlive[2];
    int mX[2];
    int mW[2];
    int mH[2];
    int mY[2];
    int mFrames[2];

    bit       curRst = 1'b1;
    bit       curNf = 1'b0;
    bit       curSp = 1'b0;
    bit [7:0] curRnd = 8'h00;

    function automatic void modelReset();
        for (int v = 0; v < 2; v++) begin
            mAlive[v] = 0; mX[v] = 640; mW[v] = 0; mH[v] = 0; mY[v] = 0; mFrames[v] = 0;
        end
    endfunction

    function automatic void modelFrame(int v, bit spawn, bit [7:0] r);
        if (mAlive[v] == 0) begin
            if (spawn) begin
                mAlive[v] = 1;
                mX[v] = 640;
                mFrames[v] = 0;
                if (v == 0) begin
                    mW[v] = r[0] ? 24 : 12;
                    mH[v] = r[1] ? 48 : 24;
                    mY[v] = 400 - mH[v];
                end else begin
                    mW[v] = 32;
                    mH[v] = 16;
                    case (r[1:0])
                        2'd0:    mY[v] = 384;
                        2'd2:    mY[v] = 336;
                        default: mY[v] = 360;
                    endcase
                end
            end
        end else begin
            mX[v] = mX[v] - 4;
            mFrames[v]++;
            if (mX[v] <= -mW[v]) mAlive[v] = 0;
        end
    endfunction

    function automatic bit expPixel(int v, int px, int py);
        int lx, ly;
        bit wingDown;
        if (mAlive[v] == 0) return 1'b0;
        if (px < mX[v] || px >= mX[v] + mW[v]) return 1'b0;
        if (py < mY[v] || py >= mY[v] + mH[v]) return 1'b0;
        if (v == 0) return 1'b1;
        lx = px - mX[v];
        ly = py - mY[v];
        wingDown = ((mFrames[v] / 8) % 2) == 1;
        if (ly >= 6 && ly <= 9) return 1'b1;
        if (lx >= 12 && lx <= 19) return wingDown ? (ly >= 10) : (ly <= 5);
        return 1'b0;
    endfunction

    function automatic int clampInt(int val, int hi);
        if (val < 0) return 0;
        if (val > hi) return hi;
        return val;
    endfunction

    // One clock cycle: advance the model for the edge just taken, drive new inputs, queue expectation.
    task automatic applyStimulus(bit nfIn, bit spIn, bit [7:0] rIn, int px, int py, bit rstIn, string tag);
        exp_t e;
        int cx, cy;
        @(posedge clk);
        if (!curRst && curNf) begin
            modelFrame(0, curSp, curRnd);
            modelFrame(1, curSp, curRnd);
        end
        #1;
        cx = clampInt(px, 639);
        cy = clampInt(py, 479);
        nf = nfIn; sp = spIn; rnd = rIn; rst = rstIn;
        pixX = 10'(cx); pixY = 10'(cy);
        curNf = nfIn; curSp = spIn; curRnd = rIn; curRst = rstIn;
        if (rstIn) modelReset();
        e.tag  = tag;
        e.pixC = expPixel(0, cx, cy);
        e.actC = (mAlive[0] != 0);
        e.pixB = expPixel(1, cx, cy);
        e.actB = (mAlive[1] != 0);
        sb.push_back(e);
    endtask

    // Random pixel near one of the live obstacles, or anywhere on screen.
    task automatic pickPixel(output int px, output int py);
        int v;
        v = int'($urandom_range(0, 1));
        if (mAlive[v] != 0) begin
            px = mX[v] + int'($urandom_range(0, 40)) - 4;
            py = mY[v] + int'($urandom_range(0, 56)) - 4;
        end else begin
            px = int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 479));
        end
    endtask

    task automatic randomFrame(bit spIn, bit [7:0] rIn, int scans, string tag);
        int px, py;
        pickPixel(px, py);
        applyStimulus(1'b1, spIn, rIn, px, py, 1'b0, tag);
        for (int i = 0; i < scans; i++) begin
            pickPixel(px, py);
            applyStimulus(1'b0, spIn, rIn, px, py, 1'b0, tag);
        end
    endtask

    task automatic checkOutput(string tag, bit actual, bit required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0b required=%0b", tag, actual, required);
        end
    endtask

    // Monitor: outputs are combinational, so one queued expectation is checked per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, ".cactus.pixel"}, pixC, e.pixC);
            checkOutput({e.tag, ".cactus.active"}, actC, e.actC);
            checkOutput({e.tag, ".bird.pixel"}, pixB, e.pixB);
            checkOutput({e.tag, ".bird.active"}, actB, e.actB);
        end
    end

    initial begin
        int px;
        modelReset();

        applyStimulus(1'b0, 1'b0, 8'h00, 10, 10, 1'b1, "reset");
        applyStimulus(1'b0, 1'b0, 8'h00, 0, 0, 1'b0, "reset");
        for (int i = 0; i < 3; i++) randomFrame(1'b0, 8'($urandom), 12, "idleScan");

        $display("[TB] cactus 8'h03 placement");
        applyStimulus(1'b1, 1'b1, 8'h03, 0, 0, 1'b0, "c03Spawn");
        applyStimulus(1'b1, 1'b0, 8'h03, 0, 0, 1'b0, "c03Move");
        applyStimulus(1'b0, 1'b0, 8'h03, 636, 352, 1'b0, "c03In");
        applyStimulus(1'b0, 1'b0, 8'h03, 635, 352, 1'b0, "c03Left");
        applyStimulus(1'b0, 1'b0, 8'h03, 636, 351, 1'b0, "c03Above");
        applyStimulus(1'b0, 1'b0, 8'h03, 636, 399, 1'b0, "c03Bottom");
        applyStimulus(1'b0, 1'b0, 8'h03, 636, 400, 1'b0, "c03Ground");

        $display("[TB] lifetime with spawn held");
        applyStimulus(1'b0, 1'b0, 8'h00, 0, 0, 1'b1, "lifeReset");
        for (int i = 0; i < 175; i++) randomFrame(1'b1, 8'h00, 2, "life");

        $display("[TB] reset while active");
        applyStimulus(1'b0, 1'b1, 8'h01, 0, 0, 1'b0, "midRst");
        for (int i = 0; i < 6; i++) randomFrame(1'b0, 8'h01, 2, "midRst");
        applyStimulus(1'b0, 1'b0, 8'h01, mX[0], mY[0] + 1, 1'b0, "preRst");
        applyStimulus(1'b0, 1'b0, 8'h01, mX[0], mY[0] + 1, 1'b1, "inRst");
        applyStimulus(1'b1, 1'b1, 8'h01, mX[0], mY[0] + 1, 1'b1, "holdRst");
        applyStimulus(1'b0, 1'b0, 8'h01, 0, 0, 1'b0, "relRst");
        for (int i = 0; i < 3; i++) randomFrame(1'b1, 8'h01, 3, "respawn");

        $display("[TB] bird 8'h02 wing cycle");
        applyStimulus(1'b0, 1'b0, 8'h02, 0, 0, 1'b1, "b02Reset");
        applyStimulus(1'b1, 1'b1, 8'h02, 0, 0, 1'b0, "b02Spawn");
        for (int f = 0; f < 20; f++) begin
            px = mX[1] + 12;
            applyStimulus(1'b0, 1'b0, 8'h02, px, 336, 1'b0, "b02WingUp");
            applyStimulus(1'b0, 1'b0, 8'h02, px, 346, 1'b0, "b02WingDown");
            applyStimulus(1'b0, 1'b0, 8'h02, px, 342, 1'b0, "b02Body");
            applyStimulus(1'b1, 1'b0, 8'h02, px + 8, 335, 1'b0, "b02Pulse");
        end

        $display("[TB] bird 8'h03 rows");
        applyStimulus(1'b0, 1'b0, 8'h03, 0, 0, 1'b1, "b03Reset");
        applyStimulus(1'b1, 1'b1, 8'h03, 0, 0, 1'b0, "b03Spawn");
        for (int f = 0; f < 12; f++) begin
            px = mX[1] + 15;
            applyStimulus(1'b0, 1'b0, 8'h03, px, 359, 1'b0, "b03Row359");
            applyStimulus(1'b0, 1'b0, 8'h03, px, 360, 1'b0, "b03Row360");
            applyStimulus(1'b0, 1'b0, 8'h03, px, 368, 1'b0, "b03Row368");
            applyStimulus(1'b0, 1'b0, 8'h03, px, 375, 1'b0, "b03Row375");
            applyStimulus(1'b0, 1'b0, 8'h03, px, 376, 1'b0, "b03Row376");
            applyStimulus(1'b1, 1'b0, 8'h03, px, 370, 1'b0, "b03Pulse");
        end

        $display("[TB] randomized play");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyStimulus(1'b0, 1'b0, 8'h00, 0, 0, 1'b1, "rndReset");
            end
            randomFrame(($urandom_range(0, 2) != 0), 8'($urandom), 2, "random");
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain actual=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/obstacle.md
# obstacle

Scrolling obstacle generator for the Dino-Run game: one moving obstacle (cactus or bird, chosen by parameter) that spawns at the right screen edge, scrolls left once per video frame and despawns off the left edge. It sits between the game controller (which supplies the frame tick, spawn request and random byte) and the pixel mixer. For each scanned screen coordinate it reports whether that pixel belongs to the obstacle.

## Interface
- `IsBird`, default 0: 0 = cactus variant, 1 = bird variant.
- `Speed`, default 4: pixels moved left per frame.
- `GroundY`, default 400: screen row of the ground line; obstacle bottoms rest at or above it.
- Screen size comes from `dinorun_pkg`: `ScreenWidth` = 640, `ScreenHeight` = 480.

- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `next_frame_i` input 1: one-cycle pulse at the end of each frame.
- `spawn_i` input 1: spawn request, level; sampled only on `next_frame_i` cycles.
- `rand_i` input 8: random byte that selects the variant; sampled at spawn.
- `pixel_x_i` input 10: current pixel column, 0..639.
- `pixel_y_i` input 10: current pixel row, 0..479.
- `pixel_o` output 1: current pixel is obstacle-coloured.
- `active_o` output 1: obstacle is currently alive.

## Operation
- Two states, IDLE and ACTIVE.
- State registers:
  - `x`: signed 11-bit, left edge of the obstacle.
  - `y_top`: 10-bit.
  - `w`, `h`: sprite size.
  - `flap`: 1 bit, bird only.
  - `frame_cnt`: 3 bits, bird only.
- IDLE: on a cycle with `next_frame_i` = 1 and `spawn_i` = 1:
  - Set `x` = `ScreenWidth` (640) and latch the variant from `rand_i`.
  - Go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE: on each `next_frame_i` pulse, `x` ← `x` − `Speed`.
  - If the new `x` is ≤ −`w`, go to IDLE. `spawn_i` is ignored in that same cycle, so respawn happens on the next pulse at the earliest.
- Cactus variant, latched at spawn:
  - `w` = 12 if `rand_i[0]` = 0, else 24.
  - `h` = 24 if `rand_i[1]` = 0, else 48.
  - `y_top` = `GroundY` − `h`.
  - Sprite is a solid rectangle.
- Bird variant:
  - `w` = 32, `h` = 16.
  - `y_top` from `rand_i[1:0]`: 0 → `GroundY`−16; 1 or 3 → `GroundY`−40; 2 → `GroundY`−64.
  - Sprite rows are local 0..15.
  - Body rows 6..9 span all columns.
  - `flap` = 0 (wing up): rows 0..5, columns 12..19.
  - `flap` = 1 (wing down): rows 10..15, columns 12..19.
  - `frame_cnt` increments on every `next_frame_i` pulse while ACTIVE; `flap` toggles when `frame_cnt` wraps 7→0, i.e. every 8 frames.
  - `flap` and `frame_cnt` are cleared at spawn.
- `pixel_o` is 1 only when all of these hold:
  - the block is ACTIVE;
  - `x` ≤ `pixel_x_i` < `x` + `w`, compared as signed 12-bit with `pixel_x_i` zero-extended;
  - `y_top` ≤ `pixel_y_i` < `y_top` + `h`;
  - the sprite bit at the local coordinate is 1.
- Partially off-screen obstacles (negative `x`, or `x` + `w` > 640) are clipped naturally by the compare; there is no wrap.
- `active_o` = 1 in the ACTIVE state.

## Timing
- `pixel_o` is combinational from the registered state and the pixel inputs: zero-cycle latency.
- All state updates happen at the rising edge of `clk_i`, and only in cycles where `next_frame_i` = 1.
- Effects are visible from the following cycle.
- `rst_i` asserted at any time, including mid-frame, immediately forces:
  - the IDLE state;
  - `x` = 640, `y_top` = 0, `w` = 0, `h` = 0;
  - `flap` = 0, `frame_cnt` = 0.
  - Consequently `pixel_o` = 0 and `active_o` = 0 while reset is held.
- If `next_frame_i` is held for several cycles, each high cycle counts as one frame. The controller must pulse it for exactly one cycle.

## Test plan
- Reset, then scan a whole frame with `spawn_i` = 0: `pixel_o` stays 0 and `active_o` = 0.
- Cactus, `rand_i` = 8'h03, spawn on the first pulse:
  - After the 2nd pulse, `x` = 636.
  - Pixel (636,352) → 1; pixel (635,352) → 0; pixel (636,351) → 0; pixel (636,399) → 1.
- Cactus, `rand_i` = 8'h00, spawn held every frame:
  - Goes IDLE on the frame where `x` reaches −12, i.e. after 163 moves.
  - Respawns at `x` = 640 on the next pulse.
- Bird, `rand_i` = 8'h02: `y_top` = 336.
  - Row 336 at a wing column (x + 12) → 1 during frames 0..7.
  - Row 346 at the same column → 1 during frames 8..15.
  - Body row 342 → 1 at all times.
- Bird, `rand_i` = 8'h03: sprite occupies rows 360..375.
- Assert `rst_i` mid-scan while ACTIVE: `pixel_o` drops to 0 combinationally, `active_o` = 0, and the next spawn restarts at `x` = 640.
